// File: rtl/wb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter_pkg
// Description : Shared types for the copperv Wishbone arbiter: arbiter state
//               encoding, upstream port identifiers and a helper that sizes
//               the timeout counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUS  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      arb_port_inst = 1'b0,
      arb_port_data = 1'b1
   } arb_port_e;

   // Width of a counter that must hold 0..cycles. A disabled timeout
   // (cycles == 0) still gets a 1-bit counter so no zero-width vector exists.
   function automatic int tmo_cnt_width(input int cycles);
      return (cycles > 0) ? $clog2(cycles + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_if.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_if
// Description : Classic Wishbone bundle shared by the core ports and the
//               system memory bus.
// Ports       : master drives cyc/stb/we/adr/sel/datwr, slave drives
//               ack/datrd.
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbone_if #(
   parameter int addr_width = 32,
   parameter int data_width = 32
);
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [addr_width-1:0]   adr;
   logic [data_width/8-1:0] sel;
   logic [data_width-1:0]   datwr;
   logic [data_width-1:0]   datrd;
   logic                    ack;

   modport master (output cyc, stb, we, adr, sel, datwr, input  ack, datrd);
   modport slave  (input  cyc, stb, we, adr, sel, datwr, output ack, datrd);
endinterface
`default_nettype wire

// File: rtl/wb_bus_arbiter_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : wb_req_latch
// Description : Captures one single-cycle upstream request and holds it until
//               the arbiter has answered it.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_stb, i_adr, i_we, i_sel, i_datwr - request pulse and fields
//               i_clear           - response cycle for this port
//               o_pending, o_adr, o_we, o_sel, o_datwr - held request
//               o_overrun         - pulse: request dropped because one is held
// Revision    : 1.0 - initial release
// ============================================================================
module wb_req_latch #(
   parameter int addr_width = 32,
   parameter int data_width = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_stb,
   input  logic [addr_width-1:0]   i_adr,
   input  logic                    i_we,
   input  logic [data_width/8-1:0] i_sel,
   input  logic [data_width-1:0]   i_datwr,
   input  logic                    i_clear,
   output logic                    o_pending,
   output logic [addr_width-1:0]   o_adr,
   output logic                    o_we,
   output logic [data_width/8-1:0] o_sel,
   output logic [data_width-1:0]   o_datwr,
   output logic                    o_overrun
);
   logic                    r_pending;
   logic [addr_width-1:0]   r_adr;
   logic                    r_we;
   logic [data_width/8-1:0] r_sel;
   logic [data_width-1:0]   r_datwr;
   logic                    w_accept;

   // A request landing in the response cycle is taken: set wins over clear.
   assign w_accept  = i_stb && (!r_pending || i_clear);
   assign o_overrun = i_stb && r_pending && !i_clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= 1'b0;
         r_adr     <= '0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_datwr   <= '0;
      end else if (w_accept) begin
         r_pending <= 1'b1;
         r_adr     <= i_adr;
         r_we      <= i_we;
         r_sel     <= i_sel;
         r_datwr   <= i_datwr;
      end else if (i_clear) begin
         r_pending <= 1'b0;
      end
   end

   assign o_pending = r_pending;
   assign o_adr     = r_adr;
   assign o_we      = r_we;
   assign o_sel     = r_sel;
   assign o_datwr   = r_datwr;
endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter
// Description : Two-into-one Wishbone arbiter. Latches single-cycle requests
//               from the core's instruction and data ports and replays them
//               one at a time as classic cycles on the memory bus, with
//               round-robin tie break and an optional bus timeout.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               inst_if      - instruction port from the core (slave side)
//               data_if      - data port from the core (slave side)
//               mem_if       - downstream memory bus (master side)
//               timeout_err  - sticky, a downstream cycle was aborted
//               overrun_err  - sticky, a request hit an already busy port
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter
   import wb_bus_arbiter_pkg::*;
#(
   parameter int                    addr_width     = 32,
   parameter int                    data_width     = 32,
   parameter int                    timeout_cycles = 255,
   parameter logic [data_width-1:0] timeout_data   = data_width'(32'hDEAD_BEEF)
) (
   input  logic       clk,
   input  logic       rst,
   wishbone_if.slave  inst_if,
   wishbone_if.slave  data_if,
   wishbone_if.master mem_if,
   output logic       timeout_err,
   output logic       overrun_err
);
   localparam int c_sel_w   = data_width / 8;
   localparam int c_tmo_w   = tmo_cnt_width(timeout_cycles);
   localparam bit c_tmo_en  = (timeout_cycles > 0);
   localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(timeout_cycles);

   // Upstream cyc carries no information for single-pulse requests.
   logic w_unused_cyc;
   assign w_unused_cyc = inst_if.cyc ^ data_if.cyc;

   // ---------------------------------------------------------------- latches
   logic                  w_pend_inst, w_pend_data;
   logic                  w_clr_inst,  w_clr_data;
   logic                  w_ovr_inst,  w_ovr_data;
   logic [addr_width-1:0] w_adr_inst,  w_adr_data;
   logic                  w_we_inst,   w_we_data;
   logic [c_sel_w-1:0]    w_sel_inst,  w_sel_data;
   logic [data_width-1:0] w_dat_inst,  w_dat_data;

   wb_req_latch #(.addr_width(addr_width), .data_width(data_width)) u_inst_latch (
      .clk(clk), .rst(rst),
      .i_stb(inst_if.stb), .i_adr(inst_if.adr), .i_we(inst_if.we),
      .i_sel(inst_if.sel), .i_datwr(inst_if.datwr), .i_clear(w_clr_inst),
      .o_pending(w_pend_inst), .o_adr(w_adr_inst), .o_we(w_we_inst),
      .o_sel(w_sel_inst), .o_datwr(w_dat_inst), .o_overrun(w_ovr_inst)
   );

   wb_req_latch #(.addr_width(addr_width), .data_width(data_width)) u_data_latch (
      .clk(clk), .rst(rst),
      .i_stb(data_if.stb), .i_adr(data_if.adr), .i_we(data_if.we),
      .i_sel(data_if.sel), .i_datwr(data_if.datwr), .i_clear(w_clr_data),
      .o_pending(w_pend_data), .o_adr(w_adr_data), .o_we(w_we_data),
      .o_sel(w_sel_data), .o_datwr(w_dat_data), .o_overrun(w_ovr_data)
   );

   // ------------------------------------------------------------------ state
   arb_state_e            r_state, w_state_next;
   arb_port_e             r_grant, r_last_grant, w_grant_sel;
   logic [c_tmo_w-1:0]    r_tmo_cnt, w_cnt_inc;
   logic                  w_load, w_to_resp, w_expire;

   logic                  r_mem_cyc, r_mem_stb, r_mem_we;
   logic [addr_width-1:0] r_mem_adr;
   logic [c_sel_w-1:0]    r_mem_sel;
   logic [data_width-1:0] r_mem_datwr;
   logic                  r_ack_inst, r_ack_data;
   logic [data_width-1:0] r_resp_dat;
   logic                  r_timeout_err, r_overrun_err;

   assign w_cnt_inc = r_tmo_cnt + c_tmo_w'(1);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ARB_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_grant_sel  = arb_port_inst;
      w_load       = 1'b0;
      w_to_resp    = 1'b0;
      w_expire     = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_pend_inst && w_pend_data) begin
               // Tie: alternate away from whoever was served last.
               w_grant_sel = (r_last_grant == arb_port_inst) ? arb_port_data : arb_port_inst;
            end else if (w_pend_data) begin
               w_grant_sel = arb_port_data;
            end
            if (w_pend_inst || w_pend_data) begin
               w_load       = 1'b1;
               w_state_next = ARB_BUS;
            end
         end
         ARB_BUS: begin
            // A slave ack on the expiry cycle still counts as a normal finish.
            if (mem_if.ack) begin
               w_to_resp    = 1'b1;
               w_state_next = ARB_RESP;
            end else if (c_tmo_en && (w_cnt_inc == c_tmo_limit)) begin
               w_to_resp    = 1'b1;
               w_expire     = 1'b1;
               w_state_next = ARB_RESP;
            end
         end
         ARB_RESP: w_state_next = ARB_IDLE;
         default:  w_state_next = ARB_IDLE;
      endcase
   end

   assign w_clr_inst = (r_state == ARB_RESP) && (r_grant == arb_port_inst);
   assign w_clr_data = (r_state == ARB_RESP) && (r_grant == arb_port_data);

   // --------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant       <= arb_port_inst;
         r_last_grant  <= arb_port_inst;
         r_tmo_cnt     <= '0;
         r_mem_cyc     <= 1'b0;
         r_mem_stb     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_adr     <= '0;
         r_mem_sel     <= '0;
         r_mem_datwr   <= '0;
         r_ack_inst    <= 1'b0;
         r_ack_data    <= 1'b0;
         r_resp_dat    <= '0;
         r_timeout_err <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         if (w_load) begin
            r_grant     <= w_grant_sel;
            r_tmo_cnt   <= '0;
            r_mem_cyc   <= 1'b1;
            r_mem_stb   <= 1'b1;
            r_mem_we    <= (w_grant_sel == arb_port_data) ? w_we_data  : w_we_inst;
            r_mem_adr   <= (w_grant_sel == arb_port_data) ? w_adr_data : w_adr_inst;
            r_mem_sel   <= (w_grant_sel == arb_port_data) ? w_sel_data : w_sel_inst;
            r_mem_datwr <= (w_grant_sel == arb_port_data) ? w_dat_data : w_dat_inst;
         end else if ((r_state == ARB_BUS) && !w_to_resp && (r_tmo_cnt != '1)) begin
            // Saturating so a disabled timeout never wraps.
            r_tmo_cnt <= w_cnt_inc;
         end

         if (w_to_resp) begin
            r_mem_cyc  <= 1'b0;
            r_mem_stb  <= 1'b0;
            r_resp_dat <= (w_expire && !r_mem_we) ? timeout_data : mem_if.datrd;
         end

         r_ack_inst <= w_to_resp && (r_grant == arb_port_inst);
         r_ack_data <= w_to_resp && (r_grant == arb_port_data);

         if (r_state == ARB_RESP) r_last_grant  <= r_grant;
         if (w_expire)            r_timeout_err <= 1'b1;
         if (w_ovr_inst || w_ovr_data) r_overrun_err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign mem_if.cyc   = r_mem_cyc;
   assign mem_if.stb   = r_mem_stb;
   assign mem_if.we    = r_mem_we;
   assign mem_if.adr   = r_mem_adr;
   assign mem_if.sel   = r_mem_sel;
   assign mem_if.datwr = r_mem_datwr;

   assign inst_if.ack   = r_ack_inst;
   assign inst_if.datrd = r_resp_dat;
   assign data_if.ack   = r_ack_data;
   assign data_if.datrd = r_resp_dat;

   assign timeout_err = r_timeout_err;
   assign overrun_err = r_overrun_err;
endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_arbiter
// Description : Self-checking bench for wb_bus_arbiter. A timestamp-based
//               transaction model predicts grant order, downstream cycle
//               windows, upstream acks and sticky error flags.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;
   localparam int          c_tmo      = 4;
   localparam logic [31:0] c_tmo_data = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic timeout_err, overrun_err;

   wishbone_if #(.addr_width(32), .data_width(32)) inst_bus ();
   wishbone_if #(.addr_width(32), .data_width(32)) data_bus ();
   wishbone_if #(.addr_width(32), .data_width(32)) mem_bus ();

   wb_bus_arbiter #(
      .addr_width(32), .data_width(32),
      .timeout_cycles(c_tmo), .timeout_data(c_tmo_data)
   ) dut (
      .clk(clk), .rst(rst),
      .inst_if(inst_bus), .data_if(data_bus), .mem_if(mem_bus),
      .timeout_err(timeout_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;

   // stimulus for the coming cycle (port 0 = inst, 1 = data)
   bit          st_v[2] = '{0, 0};
   logic [31:0] st_adr[2], st_dat[2];
   logic        st_we[2];
   logic [3:0]  st_sel[2];
   bit          st_rst = 1'b0;
   int          st_wait = -1;
   bit          st_rdata_v = 1'b0;
   logic [31:0] st_rdata;

   // reference model
   bit          m_pend[2] = '{0, 0};
   logic [31:0] m_adr[2], m_dat[2];
   logic        m_we[2];
   logic [3:0]  m_sel[2];
   int          m_last = 0;
   bit          m_active = 1'b0;
   int          m_grant = 0, m_start = 0, m_resp = 0, m_idle_from = 0;
   bit          m_tmo = 1'b0, m_terr = 1'b0, m_oerr = 1'b0;
   logic [31:0] m_rdata;

   // slave behaviour and observation records
   int          s_wait = 0, s_cnt = 0;
   logic [31:0] s_data = '0;
   int          acks_seen[2] = '{0, 0};
   int          ack_cyc[2]   = '{0, 0};
   logic [31:0] ack_dat[2];
   int          cyc_run = 0, last_run = 0;
   int          grants[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
      end
   endtask

   task automatic req(input int p, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat);
      st_v[p] = 1'b1; st_we[p] = we; st_adr[p] = adr; st_sel[p] = sel; st_dat[p] = dat;
   endtask

   task automatic step();
      bit   exp_cyc, resp_now, clr;
      logic s_ack;
      @(posedge clk); #1;
      cyc_n++;
      exp_cyc  = m_active && (cyc_n >= m_start) && (cyc_n < m_resp);
      resp_now = m_active && (cyc_n == m_resp);

      check("mem_cyc", mem_bus.cyc, exp_cyc);
      check("mem_stb", mem_bus.stb, exp_cyc);
      if (exp_cyc) begin
         check("mem_adr",   mem_bus.adr,   m_adr[m_grant]);
         check("mem_we",    mem_bus.we,    m_we[m_grant]);
         check("mem_sel",   mem_bus.sel,   m_sel[m_grant]);
         check("mem_datwr", mem_bus.datwr, m_dat[m_grant]);
      end
      check("inst_ack", inst_bus.ack, resp_now && m_grant == 0);
      check("data_ack", data_bus.ack, resp_now && m_grant == 1);
      if (resp_now && !m_we[m_grant])
         check("resp_datrd", (m_grant == 1) ? data_bus.datrd : inst_bus.datrd, m_rdata);
      check("timeout_err", timeout_err, m_terr);
      check("overrun_err", overrun_err, m_oerr);

      if (inst_bus.ack === 1'b1) begin acks_seen[0]++; ack_cyc[0] = cyc_n; ack_dat[0] = inst_bus.datrd; end
      if (data_bus.ack === 1'b1) begin acks_seen[1]++; ack_cyc[1] = cyc_n; ack_dat[1] = data_bus.datrd; end
      if (mem_bus.cyc === 1'b1) cyc_run++;
      else if (cyc_run > 0) begin last_run = cyc_run; cyc_run = 0; end

      // arbitration: a request visible in this cycle starts on the bus next cycle
      if (!m_active && cyc_n >= m_idle_from && (m_pend[0] || m_pend[1])) begin
         m_grant = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
         grants.push_back(m_grant);
         m_active = 1'b1;
         m_start  = cyc_n + 1;
         if (st_wait >= 0) s_wait = st_wait;
         else s_wait = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 3));
         st_wait = -1;
         s_data = st_rdata_v ? st_rdata : $urandom;
         st_rdata_v = 1'b0;
         m_tmo   = (s_wait >= c_tmo);
         m_resp  = m_tmo ? m_start + c_tmo : m_start + s_wait + 1;
         m_rdata = m_tmo ? c_tmo_data : s_data;
      end

      // drive inputs for this cycle
      s_ack = (mem_bus.cyc === 1'b1) && (mem_bus.stb === 1'b1) && (s_cnt == s_wait);
      mem_bus.ack   = s_ack;
      mem_bus.datrd = s_ack ? s_data : $urandom;
      s_cnt = (mem_bus.cyc === 1'b1) ? s_cnt + 1 : 0;
      rst = st_rst;
      inst_bus.stb   = st_v[0];
      inst_bus.cyc   = st_v[0];
      inst_bus.we    = st_v[0] ? st_we[0]  : 1'($urandom);
      inst_bus.adr   = st_v[0] ? st_adr[0] : $urandom;
      inst_bus.sel   = st_v[0] ? st_sel[0] : 4'($urandom);
      inst_bus.datwr = st_v[0] ? st_dat[0] : $urandom;
      data_bus.stb   = st_v[1];
      data_bus.cyc   = st_v[1];
      data_bus.we    = st_v[1] ? st_we[1]  : 1'($urandom);
      data_bus.adr   = st_v[1] ? st_adr[1] : $urandom;
      data_bus.sel   = st_v[1] ? st_sel[1] : 4'($urandom);
      data_bus.datwr = st_v[1] ? st_dat[1] : $urandom;

      // advance the model by the effect of this cycle's inputs
      if (st_rst) begin
         m_pend = '{0, 0};
         m_last = 0; m_active = 1'b0; m_idle_from = cyc_n + 1;
         m_terr = 1'b0; m_oerr = 1'b0;
         s_cnt = 0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            clr = resp_now && (m_grant == p);
            if (st_v[p]) begin
               if (m_pend[p] && !clr) m_oerr = 1'b1;
               else begin
                  m_pend[p] = 1'b1;
                  m_adr[p] = st_adr[p]; m_we[p] = st_we[p];
                  m_sel[p] = st_sel[p]; m_dat[p] = st_dat[p];
               end
            end else if (clr) m_pend[p] = 1'b0;
         end
         if (m_active && m_tmo && cyc_n == m_resp - 1) m_terr = 1'b1;
         if (resp_now) begin
            m_last = m_grant; m_active = 1'b0; m_idle_from = cyc_n + 1;
         end
      end
      st_v = '{0, 0};
      st_rst = 1'b0;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin st_rst = 1'b1; step(); end
      step();
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (m_active || m_pend[0] || m_pend[1]); i++) step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, a0, a1, found;
      inst_bus.stb = 1'b0; inst_bus.cyc = 1'b0; inst_bus.we = 1'b0;
      inst_bus.adr = '0; inst_bus.sel = '0; inst_bus.datwr = '0;
      data_bus.stb = 1'b0; data_bus.cyc = 1'b0; data_bus.we = 1'b0;
      data_bus.adr = '0; data_bus.sel = '0; data_bus.datwr = '0;
      mem_bus.ack = 1'b0; mem_bus.datrd = '0;

      // reset state
      do_reset(3);
      check("rst_mem_we",     mem_bus.we,     0);
      check("rst_mem_adr",    mem_bus.adr,    0);
      check("rst_mem_sel",    mem_bus.sel,    0);
      check("rst_mem_datwr",  mem_bus.datwr,  0);
      check("rst_inst_datrd", inst_bus.datrd, 0);
      check("rst_data_datrd", data_bus.datrd, 0);

      // single read, zero-wait slave
      st_wait = 0; st_rdata = 32'h0000_0013; st_rdata_v = 1'b1;
      a1 = acks_seen[1];
      req(0, 1'b0, 32'h100, 4'hF, 32'h0);
      step(); p0 = cyc_n;
      drain();
      check("read_latency", ack_cyc[0] - p0, 3);
      check("read_datrd", ack_dat[0], 32'h0000_0013);
      check("read_no_data_ack", acks_seen[1], a1);

      // byte write through 3 wait states
      st_wait = 3;
      req(1, 1'b1, 32'h2000, 4'b0100, 32'h00AB_0000);
      step(); p0 = cyc_n;
      drain();
      check("write_latency", ack_cyc[1] - p0, 6);

      // simultaneous pulses after reset; the second pair lands in the
      // response cycle of the data transaction
      do_reset(1);
      grants.delete();
      req(0, 1'b0, 32'h300, 4'hF, $urandom);
      req(1, 1'b0, 32'h400, 4'hF, $urandom);
      step();
      found = 0;
      for (int i = 0; i < 30; i++) begin
         if (m_active && m_grant == 1 && cyc_n + 1 == m_resp) begin found = 1; break; end
         step();
      end
      check("pair_sync", found, 1);
      req(0, 1'b0, 32'h500, 4'hF, $urandom);
      req(1, 1'b1, 32'h600, 4'h3, $urandom);
      step();
      drain();
      check("grant_cnt", grants.size(), 3);
      if (grants.size() == 3) begin
         check("grant_first",  grants[0], 1);
         check("grant_second", grants[1], 0);
         check("grant_third",  grants[2], 1);
      end

      // overrun: second inst pulse while pending is dropped
      do_reset(1);
      a0 = acks_seen[0];
      req(0, 1'b0, 32'h100, 4'hF, 32'h0);
      step();
      req(0, 1'b0, 32'h104, 4'hF, 32'h0);
      step();
      drain();
      repeat (3) step();
      check("ovr_flag", overrun_err, 1);
      check("ovr_single_ack", acks_seen[0] - a0, 1);

      // timeout on a read
      st_wait = 1000;
      req(0, 1'b0, 32'h800, 4'hF, 32'h0);
      step();
      drain();
      check("tmo_cyc_len", last_run, c_tmo);
      check("tmo_datrd", ack_dat[0], c_tmo_data);
      repeat (5) step();
      check("tmo_sticky", timeout_err, 1);

      // reset during the bus phase
      st_wait = 3;
      req(1, 1'b0, 32'hA00, 4'hF, 32'h0);
      step(); step(); step();
      check("mid_bus_active", mem_bus.cyc, 1);
      a0 = acks_seen[0]; a1 = acks_seen[1];
      st_rst = 1'b1; step();
      step();
      check("mid_rst_cyc", mem_bus.cyc, 0);
      repeat (8) step();
      check("mid_rst_no_ack", acks_seen[0] + acks_seen[1], a0 + a1);
      st_wait = 1;
      req(1, 1'b0, 32'hB00, 4'hF, 32'h0);
      step();
      drain();
      check("post_rst_ack", acks_seen[1] - a1, 1);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         for (int p = 0; p < 2; p++)
            if ($urandom_range(0, 4) == 0)
               req(p, 1'($urandom), $urandom & 32'hFFFF_FFFC, 4'($urandom), $urandom);
         step();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-into-one Wishbone arbiter between the copperv core and the single system memory bus. It takes the core's instruction-fetch and data ports, which raise `stb` as single-cycle request pulses, and latches each request. It issues the latched requests one at a time as standard classic Wishbone cycles on a downstream master port. Each response is returned to the originating port as a one-cycle `ack` with the read data valid in the same cycle.

## Interface
- `addr_width`, 32, address width on all ports
- `data_width`, 32, data width; `sel` width is `data_width/8`
- `timeout_cycles`, 255, number of downstream cycles without `ack` before the arbiter aborts; 0 disables the timeout
- `timeout_data`, 32'hDEAD_BEEF, value returned on `datrd` for an aborted read
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `inst_if`  wishbone_if.slave  -  instruction port from the core
- `data_if`  wishbone_if.slave  -  data port from the core
- `mem_if`  wishbone_if.master  -  downstream bus
- `timeout_err`  out  1  sticky; set when any transaction times out
- `overrun_err`  out  1  sticky; set when a request arrives on a port that already has a request pending

## Operation
- **Request capture (per port).**
  - `stb`=1 while the port is not pending: latch `adr`, `we`, `sel`, `datwr` and set `pending`.
  - Upstream `cyc` is ignored.
  - `stb`=1 while the port is pending: the request is dropped, `overrun_err` is set, and the latched request is unchanged.
  - The response cycle to a port clears its `pending`. A new `stb` arriving in that same cycle is accepted, because set wins over clear.
- **States.**
  - `ARB_IDLE`: if any port is pending, select the grant and go to `ARB_BUS`.
    - Only one port pending: grant that port.
    - Both pending: grant the port that does not match `last_grant`.
    - `last_grant` resets to inst, so data wins the first tie.
  - `ARB_BUS`: `mem_if.cyc`=`stb`=1, driven from the granted port's latch. Held until `mem_if.ack` or timeout, then go to `ARB_RESP`.
  - `ARB_RESP`: registered `ack`=1 to the granted port, for one cycle only. `datrd` is the captured `mem_if.datrd`, or `timeout_data` after a timeout read. Clear that port's `pending`, update `last_grant`, go to `ARB_IDLE`.
- **Writes.**
  - `datrd` on the upstream port is don't-care.
  - A write that times out still receives `ack`, and `timeout_err` is set.
- **Timeout counter.**
  - Resets to 0 on entry to `ARB_BUS` and increments each `ARB_BUS` cycle without `ack`.
  - When it reaches `timeout_cycles`, drop `cyc`/`stb` and go to `ARB_RESP`.
  - The counter is `$clog2(timeout_cycles+1)` bits wide and never wraps.
  - `ack` in the same cycle as expiry counts as a normal completion.
- **Upstream `ack`.** Asserted only in `ARB_RESP`, and only on the granted port.

## Timing
- **Reset values:**
  - all upstream `ack`=0 and `datrd`=0
  - `mem_if.cyc`=`stb`=`we`=0, `adr`/`sel`/`datwr`=0
  - `timeout_err`=`overrun_err`=0
  - both `pending`=0, state `ARB_IDLE`, `last_grant`=inst
- **Reset mid-transaction:** `mem_if.cyc`/`stb` are low after the reset edge; pending requests are discarded and no `ack` is issued.
- **Latency:**
  - Request pulse in cycle 0 → `mem_if.stb` high in cycle 2 (latch in 0, IDLE→BUS decided in 1).
  - Slave `ack` in cycle k → upstream `ack` in cycle k+1; `mem_if.cyc` is low in cycle k+1.
  - Minimum round trip with a zero-wait slave: 0 → `ack` at cycle 3.
- **Back-to-back:** at least one `ARB_IDLE` cycle separates downstream transactions, so `mem_if.cyc` deasserts between them.
- **Downstream outputs:** all `mem_if` outputs are registered and stable for the whole `ARB_BUS` interval.

## Structure
- **Shared package (core's type package):**
  - `arb_state_e` {`ARB_IDLE`, `ARB_BUS`, `ARB_RESP`}
  - `arb_port_e` {`arb_port_inst`, `arb_port_data`}
- **Sub-module:** `wb_req_latch`, instantiated once per port.
  - Holds the request fields and `pending`, and generates the overrun pulse.
  - Inputs: `stb`, request fields, `clear`.
- **Top level:** the state machine, grant logic, timeout counter and response mux.

## Test plan
- **Single read:**
  - Stimulus: inst `stb` pulse, `adr`=0x100; slave acks on the first `ARB_BUS` cycle with 0x00000013.
  - Required: `mem_if.adr`=0x100, `we`=0; inst `ack` at cycle 3 with `datrd`=0x00000013; data port never acked.
- **Byte write:**
  - Stimulus: data `stb`, `we`=1, `sel`=4'b0100, `datwr`=0x00AB0000, `adr`=0x2000.
  - Required: identical fields on `mem_if`, held through 3 slave wait states; data `ack` one cycle after the slave `ack`.
- **Simultaneous pulses after reset:**
  - Stimulus: inst and data `stb` in the same cycle.
  - Required: data is served first, then inst. Repeat the simultaneous pulses: inst is served first this time.
- **Overrun:**
  - Stimulus: second inst `stb` while inst is pending, with `adr`=0x104.
  - Required: `overrun_err`=1; the downstream transaction uses 0x100; only one `ack` is returned.
- **Timeout:**
  - Stimulus: `timeout_cycles`=4, slave never acks a read.
  - Required: `cyc` high for exactly 4 cycles; `ack` with `datrd`=0xDEADBEEF; `timeout_err`=1 and remains set.
- **Reset mid-transaction:**
  - Stimulus: `rst` during `ARB_BUS`.
  - Required: `mem_if.cyc`=0 on the next cycle; no upstream `ack`; a new request after reset completes normally.
